sobel_rgb_joiner: RTL
=====================

# sobel_rgb_joiner

Downstream stage of the Sobel filter. It accepts the three independent 8-bit channel streams (newR, newG, newB) that the filter emits and buffers each channel in its own small FIFO. It re-packs one sample from each channel into a single 24-bit pixel and tags it with raster coordinates and end-of-frame markers. Its output feeds the frame writer/monitor.

## Interface

Parameters:
- IMG_W, 256, pixels per line (≥2)
- IMG_H, 256, lines per frame (≥2)
- FIFO_DEPTH, 4, entries per channel FIFO (power of two, ≥2)

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- i_newR_vld  in  1  R sample valid
- i_newR_data  in  8  R sample
- i_newR_busy  out  1  R FIFO cannot accept
- i_newG_vld / i_newG_data / i_newG_busy  same as R, for G
- i_newB_vld / i_newB_data / i_newB_busy  same as R, for B
- o_pix_busy  in  1  downstream stall
- o_pix_vld  out  1  packed pixel valid
- o_pix_data  out  24  {B[23:16], G[15:8], R[7:0]}, the same packing as the filter's rgb input
- o_pix_x  out  $clog2(IMG_W)  column of o_pix_data
- o_pix_y  out  $clog2(IMG_H)  row of o_pix_data
- o_pix_last  out  1  o_pix_data is the frame's final pixel
- o_frame_done  out  1  one-cycle pulse after the last pixel is accepted
- o_frame_cnt  out  16  completed frames, wraps at 65535→0

## Operation

- Handshake, all ports: a transfer occurs on a rising edge where vld=1 and busy=0. The sender holds vld and data stable until transfer. A receiver may assert busy at any time.
- Per-channel FIFO:
  - busy = FIFO full, derived from registered occupancy only.
  - No push into a full FIFO, even if a pop happens in the same cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leaves occupancy unchanged.
- Channels are independent. R may run up to FIFO_DEPTH samples ahead of G or B without loss or reordering.
- Join: output register is free when o_pix_vld=0, or when o_pix_vld=1 and o_pix_busy=0.
  - When all three FIFOs are non-empty and the output register is free, pop one entry from each FIFO.
  - Load o_pix_data, x, y and last, and set o_pix_vld.
  - Otherwise hold.
- Output free, all FIFOs non-empty, and current pixel accepted in the same cycle: load the next pixel back-to-back, keeping o_pix_vld=1. Throughput is one pixel per clock.
- Coordinate counters x and y advance on each output transfer:
  - x increments; at IMG_W-1, x wraps to 0 and y increments.
  - At x=IMG_W-1 and y=IMG_H-1, both wrap to 0.
  - o_pix_x/o_pix_y are the counter values captured when the register loads.
- o_pix_last = (x==IMG_W-1 && y==IMG_H-1) for the loaded pixel.
- o_frame_done is high for exactly the one cycle following the edge on which a last pixel transferred. o_frame_cnt increments on that same edge.
- Reset:
  - Asserting i_rst at any time, including mid-frame, empties all FIFOs and zeroes x, y and o_frame_cnt.
  - All outputs go low/zero. busy outputs are 0 in reset.
  - Partial pixels held in the FIFOs are discarded.

## Timing

- Latency: the channel transfer that completes a pixel set at edge N gives o_pix_vld=1 after edge N+1.
- Steady state, no stalls: 1 pixel/cycle.
- o_pix_busy held for k cycles:
  - Each FIFO fills after it has accepted FIFO_DEPTH samples.
  - i_newX_busy rises after the edge that fills it.
  - i_newX_busy falls the cycle after the first pop.
- o_pix_* values change only on a load edge.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure

- A shared package holds:
  - the pixel packing function (channel field offsets)
  - the coordinate width helpers
  - the frame-counter width constant (16)
- Sub-module chan_fifo (8-bit, FIFO_DEPTH, outputs full/empty), instantiated three times.
- The top level holds the join logic, output register, counters and frame pulse.

## Test plan

- Reset default: hold i_rst=0, then release. Expect all outputs 0 and all busy=0.
- Aligned stream, IMG_W=4, IMG_H=2, o_pix_busy=0:
  - Inputs: R=i, G=i+16, B=i+32 for i=0..7, presented simultaneously.
  - Expect 8 pixels back-to-back with o_pix_data=(i+32)<<16|(i+16)<<8|i.
  - x cycles 0,1,2,3,0,1,2,3; y is 0 then 1.
  - o_pix_last only on i=7.
  - o_frame_done pulses once; o_frame_cnt=1.
- Skewed channels:
  - Send all 4 R samples, then 4 G samples, then 4 B samples.
  - Expect no output until the first B transfer.
  - First pixel appears one edge after that transfer; the 4 pixels come out correctly ordered.
  - i_newR_busy=1 after the 4th R sample (FIFO_DEPTH=4).
- Backpressure:
  - Hold o_pix_busy=1 for 10 cycles while all channels stream.
  - Expect o_pix_data stable and each busy to rise once its FIFO is full.
  - After release: no drops or duplicates, and throughput returns to 1 pixel/cycle.
- Reset mid-frame:
  - Assert i_rst after 3 pixels of frame 0, with 2 R samples left in the FIFO.
  - After release, send a fresh frame. Expect its first pixel at x=0, y=0, built from new data only, with o_frame_cnt=0.
- Frame wrap:
  - Run 3 consecutive frames.
  - Expect exactly 3 o_frame_done pulses, each one cycle after the last-pixel transfer.
  - o_frame_cnt reads 3; coordinates restart at 0,0 each frame.

Source files
------------

// File: rtl/sobel_rgb_joiner_pkg.sv
// Shared definitions for the Sobel RGB joiner.
// Holds the channel/pixel widths, the frame-counter width, the coordinate
// width helper and the pixel packing function ({B,G,R}, R in the low byte).
package sobel_rgb_joiner_pkg;

  localparam int CHAN_W      = 8;
  localparam int NUM_CHAN    = 3;
  localparam int PIX_W       = NUM_CHAN * CHAN_W;
  localparam int FRAME_CNT_W = 16;

  // Field offsets inside a packed pixel; same layout as the filter's rgb input.
  localparam int R_OFS = 0;
  localparam int G_OFS = 8;
  localparam int B_OFS = 16;

  // Width of a coordinate counter covering 0..n-1 (never narrower than 1 bit).
  function automatic int coordW(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // ch[0]=R, ch[1]=G, ch[2]=B
  function automatic logic [PIX_W-1:0] packPix(input logic [NUM_CHAN-1:0][CHAN_W-1:0] ch);
    logic [PIX_W-1:0] p;
    p = '0;
    p[R_OFS +: CHAN_W] = ch[0];
    p[G_OFS +: CHAN_W] = ch[1];
    p[B_OFS +: CHAN_W] = ch[2];
    return p;
  endfunction

endpackage

// File: rtl/sobel_rgb_joiner_chan_fifo.sv
// chan_fifo: single-channel sample FIFO used once per colour channel.
// Ports:
//   clk, rstN          clock, async active-low reset
//   pushVld, pushData  write side; the write is dropped while full
//   pop                read request; ignored while empty
//   popData            head entry (valid while !empty)
//   full, empty        registered status flags
module chan_fifo
  import sobel_rgb_joiner_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = CHAN_W
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         pushVld,
  input  logic [W-1:0] pushData,
  input  logic         pop,
  output logic [W-1:0] popData,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   count, countNxt;
  logic          doPush, doPop;

  // A full FIFO refuses a push even when a pop frees a slot on the same edge,
  // so full (and the upstream busy) depends only on registered state.
  assign doPush  = pushVld && !full;
  assign doPop   = pop && !empty;
  assign popData = mem[rdPtr];

  always_comb begin
    countNxt = count;
    if (doPush && !doPop)      countNxt = count + 1'b1;
    else if (!doPush && doPop) countNxt = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      count <= countNxt;
      full  <= (countNxt == (AW+1)'(DEPTH));
      empty <= (countNxt == '0);
    end
  end

  // Storage needs no reset; occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/sobel_rgb_joiner.sv
// sobel_rgb_joiner: joins the filter's independent R/G/B sample streams into
// packed 24-bit pixels tagged with raster coordinates and frame markers.
// Ports:
//   i_clk, i_rst                       clock, async active-low reset
//   i_newX_vld/_data/_busy (X=R,G,B)   per-channel input handshake
//   o_pix_busy                         downstream stall
//   o_pix_vld/_data/_x/_y/_last        packed pixel output (registered)
//   o_frame_done                       one-cycle pulse after last pixel leaves
//   o_frame_cnt                        completed frames (wrapping)
module sobel_rgb_joiner
  import sobel_rgb_joiner_pkg::*;
#(
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256,
  parameter int FIFO_DEPTH = 4,
  localparam int XW = coordW(IMG_W),
  localparam int YW = coordW(IMG_H)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_newR_vld,
  input  logic [CHAN_W-1:0]      i_newR_data,
  output logic                   i_newR_busy,
  input  logic                   i_newG_vld,
  input  logic [CHAN_W-1:0]      i_newG_data,
  output logic                   i_newG_busy,
  input  logic                   i_newB_vld,
  input  logic [CHAN_W-1:0]      i_newB_data,
  output logic                   i_newB_busy,
  input  logic                   o_pix_busy,
  output logic                   o_pix_vld,
  output logic [PIX_W-1:0]       o_pix_data,
  output logic [XW-1:0]          o_pix_x,
  output logic [YW-1:0]          o_pix_y,
  output logic                   o_pix_last,
  output logic                   o_frame_done,
  output logic [FRAME_CNT_W-1:0] o_frame_cnt
);

  // Channel index 0=R, 1=G, 2=B throughout.
  logic [NUM_CHAN-1:0]             chVld, chFull, chEmpty;
  logic [NUM_CHAN-1:0][CHAN_W-1:0] chData, chHead;

  assign chVld  = {i_newB_vld, i_newG_vld, i_newR_vld};
  assign chData = {i_newB_data, i_newG_data, i_newR_data};
  assign i_newR_busy = chFull[0];
  assign i_newG_busy = chFull[1];
  assign i_newB_busy = chFull[2];

  logic outFree, load, xfer, atXEnd, atYEnd;
  logic [XW-1:0] x;
  logic [YW-1:0] y;

  assign outFree = !o_pix_vld || !o_pix_busy;
  assign load    = outFree && !(|chEmpty);
  assign xfer    = o_pix_vld && !o_pix_busy;
  assign atXEnd  = (x == XW'(IMG_W - 1));
  assign atYEnd  = (y == YW'(IMG_H - 1));

  for (genvar c = 0; c < NUM_CHAN; c++) begin : gChan
    chan_fifo #(.DEPTH(FIFO_DEPTH), .W(CHAN_W)) uFifo (
      .clk      (i_clk),
      .rstN     (i_rst),
      .pushVld  (chVld[c]),
      .pushData (chData[c]),
      .pop      (load),
      .popData  (chHead[c]),
      .full     (chFull[c]),
      .empty    (chEmpty[c])
    );
  end

  // Coordinates advance on each load: every loaded pixel leaves through exactly
  // one output transfer, so x/y always name the next pixel to be loaded.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      x            <= '0;
      y            <= '0;
      o_pix_vld    <= 1'b0;
      o_pix_data   <= '0;
      o_pix_x      <= '0;
      o_pix_y      <= '0;
      o_pix_last   <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_cnt  <= '0;
    end else begin
      if (load) begin
        o_pix_vld  <= 1'b1;
        o_pix_data <= packPix(chHead);
        o_pix_x    <= x;
        o_pix_y    <= y;
        o_pix_last <= atXEnd && atYEnd;
        x <= atXEnd ? '0 : x + 1'b1;
        if (atXEnd) y <= atYEnd ? '0 : y + 1'b1;
      end else if (outFree) begin
        o_pix_vld <= 1'b0;
      end
      o_frame_done <= xfer && o_pix_last;
      if (xfer && o_pix_last) o_frame_cnt <= o_frame_cnt + 1'b1;
    end
  end

endmodule
